// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-side signal bundle for the two-port data memory arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters plus memory.
interface data_mem_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int AW         = 6
);
  logic                  a_req;
  logic                  a_we;
  logic [AW-1:0]         a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic                  b_req;
  logic                  b_we;
  logic [AW-1:0]         b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  mem_write;
  logic                  mem_read;
  logic [AW-1:0]         mem_write_addr;
  logic [AW-1:0]         mem_read_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  busy;

  // Handshake: req is a level held until the one-cycle gnt pulse; the command
  // fields stay stable while req is high; rvalid pulses once and qualifies rdata.
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_read_data,
    output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, mem_write, mem_read,
           mem_write_addr, mem_read_addr, mem_write_data, busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_read_data,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, mem_write, mem_read,
           mem_write_addr, mem_read_addr, mem_write_data, busy
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter giving two requesters single-command access to a memory
// with one-cycle registered read latency (IDLE -> ISSUE -> [WAIT] -> IDLE).
module data_mem_arbiter #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int MEMORY_SIZE = 64,
  localparam int AW          = $clog2(MEMORY_SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_arbiter_if.slave   bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                state_q;
  logic                  last_b_q;
  logic                  win_b_q;
  logic                  we_q;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  a_gnt_q;
  logic                  b_gnt_q;
  logic                  a_rvalid_q;
  logic                  b_rvalid_q;
  logic                  mem_write_q;
  logic                  mem_read_q;

  logic                  win_b_d;
  logic                  we_d;
  logic [AW-1:0]         addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  // On a tie, the side not granted last wins; last_b_q resets to 1 so A wins first.
  always_comb begin
    win_b_d = 1'b0;
    if (bus.b_req && !bus.a_req) begin
      win_b_d = 1'b1;
    end else if (bus.a_req && bus.b_req) begin
      win_b_d = !last_b_q;
    end
    we_d    = win_b_d ? bus.b_we    : bus.a_we;
    addr_d  = win_b_d ? bus.b_addr  : bus.a_addr;
    wdata_d = win_b_d ? bus.b_wdata : bus.a_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_b_q    <= 1'b1;
      win_b_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.a_req || bus.b_req) begin
            win_b_q     <= win_b_d;
            last_b_q    <= win_b_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            a_gnt_q     <= !win_b_d;
            b_gnt_q     <= win_b_d;
            mem_write_q <= we_d;
            mem_read_q  <= !we_d;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (we_q) begin
            state_q <= ST_IDLE;
          end else begin
            a_rvalid_q <= !win_b_q;
            b_rvalid_q <= win_b_q;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.a_gnt          = a_gnt_q;
  assign bus.b_gnt          = b_gnt_q;
  assign bus.a_rvalid       = a_rvalid_q;
  assign bus.b_rvalid       = b_rvalid_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write_addr = addr_q;
  assign bus.mem_read_addr  = addr_q;
  assign bus.mem_write_data = wdata_q;
  // Memory read data is only meaningful in WAIT; elsewhere rdata is held at zero.
  assign bus.rdata          = (state_q == ST_WAIT) ? bus.mem_read_data : '0;
  assign bus.busy           = (state_q != ST_IDLE);
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: write/read latency, round-robin order,
// reads overlapping new requests, reset abort and back-to-back writes.
module tb_data_mem_arbiter;
  localparam int DW = 8;
  localparam int AW = 6;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         total;
  int         passed;

  data_mem_arbiter_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

  data_mem_arbiter #(.DATA_WIDTH(DW), .MEMORY_SIZE(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model with registered read data
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_write_addr] <= bus.mem_write_data;
    if (bus.mem_read)  bus.mem_read_data <= mem[bus.mem_read_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = data;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = data;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    drive_a(1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_strobes", {28'd0, bus.a_gnt, bus.b_gnt, bus.mem_write, bus.mem_read}, 32'd0);
    chk("rst_rdata", {24'd0, bus.rdata}, 32'd0);
    tick();
    reset = 1'b0;

    // A write addr 5 = 0x3C, then A read addr 5
    drive_a(1'b1, 1'b1, 6'd5, 8'h3C);
    tick();
    chk("wr_agnt", {31'd0, bus.a_gnt}, 32'd1);
    chk("wr_mem_write", {30'd0, bus.mem_write, bus.mem_read}, 32'd2);
    chk("wr_addr_data", {18'd0, bus.mem_write_addr, bus.mem_write_data}, {18'd0, 6'd5, 8'h3C});
    chk("wr_busy", {31'd0, bus.busy}, 32'd1);
    drive_a(1'b0, 1'b0, '0, '0);
    tick();
    chk("wr_done", {28'd0, bus.a_gnt, bus.mem_write, bus.mem_read, bus.busy}, 32'd0);
    drive_a(1'b1, 1'b0, 6'd5, 8'h00);
    tick();
    chk("rd_agnt", {31'd0, bus.a_gnt}, 32'd1);
    chk("rd_mem_read", {24'd0, bus.mem_write, bus.mem_read, bus.mem_read_addr}, {24'd0, 2'b01, 6'd5});
    chk("rd_no_rvalid_yet", {31'd0, bus.a_rvalid}, 32'd0);
    drive_a(1'b0, 1'b0, '0, '0);
    tick();
    chk("rd_rvalid", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd2);
    chk("rd_rdata", {24'd0, bus.rdata}, 32'h3C);
    chk("rd_wait_gnt0", {30'd0, bus.a_gnt, bus.mem_read}, 32'd0);
    tick();
    chk("rd_done", {29'd0, bus.a_rvalid, bus.busy, bus.mem_read}, 32'd0);

    // round robin after reset: A, B, A, B
    do_reset();
    drive_a(1'b1, 1'b1, 6'd1, 8'h11);
    drive_b(1'b1, 1'b1, 6'd2, 8'h22);
    tick();
    chk("rr1", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd2);
    chk("rr1_data", {24'd0, bus.mem_write_data}, 32'h11);
    drive_a(1'b0, 1'b1, 6'd1, 8'h11);
    tick();
    chk("rr1_gap", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd0);
    drive_a(1'b1, 1'b1, 6'd1, 8'h11);
    tick();
    chk("rr2", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd1);
    chk("rr2_addr", {26'd0, bus.mem_write_addr}, 32'd2);
    drive_b(1'b0, 1'b1, 6'd2, 8'h22);
    tick();
    drive_b(1'b1, 1'b1, 6'd2, 8'h22);
    tick();
    chk("rr3", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd2);
    drive_a(1'b0, 1'b1, 6'd1, 8'h11);
    tick();
    drive_a(1'b1, 1'b1, 6'd1, 8'h11);
    tick();
    chk("rr4", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd1);
    drive_b(1'b0, 1'b0, '0, '0);
    drive_a(1'b0, 1'b0, '0, '0);
    tick();

    // B writes 0xFF to 63, then B reads it while A requests during WAIT
    drive_b(1'b1, 1'b1, 6'd63, 8'hFF);
    tick();
    chk("b_wr_gnt", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd1);
    drive_b(1'b0, 1'b0, '0, '0);
    tick();
    drive_b(1'b1, 1'b0, 6'd63, 8'h00);
    tick();
    chk("b_rd_gnt", {29'd0, bus.b_gnt, bus.mem_read, bus.mem_write}, 32'd6);
    drive_b(1'b0, 1'b0, '0, '0);
    tick();
    drive_a(1'b1, 1'b1, 6'd7, 8'h77);
    chk("b_rvalid", {30'd0, bus.a_rvalid, bus.b_rvalid}, 32'd1);
    chk("b_rdata", {24'd0, bus.rdata}, 32'hFF);
    tick();
    chk("a_ignored_in_wait", {29'd0, bus.a_gnt, bus.b_rvalid, bus.busy}, 32'd0);
    tick();
    chk("a_after_wait", {29'd0, bus.a_gnt, bus.b_rvalid, bus.mem_write}, 32'd5);
    drive_a(1'b0, 1'b0, '0, '0);
    tick();

    // reset mid-WAIT aborts the A read
    drive_a(1'b1, 1'b0, 6'd5, 8'h00);
    tick();
    chk("abort_gnt", {31'd0, bus.a_gnt}, 32'd1);
    drive_a(1'b0, 1'b0, '0, '0);
    tick();
    chk("abort_in_wait", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy0", {31'd0, bus.busy}, 32'd0);
    chk("abort_outs0", {26'd0, bus.a_rvalid, bus.b_rvalid, bus.a_gnt, bus.b_gnt,
                        bus.mem_read, bus.mem_write}, 32'd0);
    chk("abort_rdata0", {24'd0, bus.rdata}, 32'd0);
    tick();
    chk("abort_hold", {30'd0, bus.a_rvalid, bus.busy}, 32'd0);

    // continuous A writes straight out of reset: grant every second cycle
    drive_a(1'b1, 1'b1, 6'd9, 8'h5A);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("cont_gnt%0d", i), {30'd0, bus.a_gnt, bus.busy},
          (i % 2 == 0) ? 32'd3 : 32'd0);
      chk($sformatf("cont_excl%0d", i), {31'd0, bus.mem_write & bus.mem_read}, 32'd0);
    end
    drive_a(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    chk("end_idle", {30'd0, dbg_state}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-002 The block SHALL have parameter MEMORY_SIZE, default 64, number of memory words; AW = $clog2(MEMORY_SIZE).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports a_req, b_req  input  1  requester A/B access request, level, held until grant.
REQ-006 The block SHALL have ports a_we, b_we  input  1  1 = write, 0 = read; stable while req high.
REQ-007 The block SHALL have ports a_addr, b_addr  input  AW  access address; stable while req high.
REQ-008 The block SHALL have ports a_wdata, b_wdata  input  DATA_WIDTH  write data; stable while req high.
REQ-009 The block SHALL have ports a_gnt, b_gnt  output  1  one-cycle grant pulse, command issued this cycle.
REQ-010 The block SHALL have ports a_rvalid, b_rvalid  output  1  one-cycle pulse, read data valid.
REQ-011 The block SHALL have port rdata  output  DATA_WIDTH  read data, shared, qualified by a_rvalid/b_rvalid.
REQ-012 The block SHALL have ports mem_write, mem_read  output  1  memory write/read strobes.
REQ-013 The block SHALL have ports mem_write_addr, mem_read_addr  output  AW  memory addresses.
REQ-014 The block SHALL have port mem_write_data  output  DATA_WIDTH  memory write data.
REQ-015 The block SHALL have port mem_read_data  input  DATA_WIDTH  memory registered read data, valid the cycle after mem_read.
REQ-016 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, all registered.
REQ-018 In IDLE, with any req high at posedge, the block SHALL latch winner, we, addr, wdata and go to ISSUE; otherwise stay IDLE.
REQ-019 Arbitration SHALL be round-robin: only one req -> it wins; both -> the port not granted last wins; after reset A has priority.
REQ-020 In ISSUE the block SHALL pulse the winner's gnt and drive mem_write (we=1) or mem_read (we=0) for exactly one cycle with latched addr/data.
REQ-021 From ISSUE, write SHALL go to IDLE; read SHALL go to WAIT.
REQ-022 In WAIT the block SHALL drive rdata = mem_read_data, pulse the winner's rvalid one cycle, go to IDLE.
REQ-023 Latency from req sampled: gnt at +1 cycle; read rvalid at +2 cycles; next arbitration edge at +2 (write) or +3 (read).
REQ-024 Outside the cycles above, all strobes, gnt and rvalid SHALL be 0; mem_write and mem_read SHALL never be high together.
REQ-025 Requester SHALL deassert req the cycle after gnt; a req still high in IDLE is a new request, arbitrated normally.
REQ-026 Req changes while the block is not in IDLE SHALL be ignored until return to IDLE.
REQ-027 Addresses pass unmodified; no wrap or range check (AW covers MEMORY_SIZE).

Reset
REQ-028 On reset high, immediately and regardless of clk: state IDLE, last-granted = B (so A wins first tie), all outputs 0, rdata 0, latched fields 0.
REQ-029 Reset during ISSUE or WAIT SHALL abort the transaction with no gnt/rvalid after reset asserts; no retry.
REQ-030 First arbitration SHALL occur at the first posedge after reset deasserts.

Verification
REQ-031 A write addr 5 data 0x3C, then A read addr 5 -> mem_write 1 cycle at +1; a_rvalid at +2 of read with rdata 0x3C.
REQ-032 A and B req same cycle after reset -> a_gnt first; both re-request at once -> b_gnt next; alternation A,B,A,B over 4 grants.
REQ-033 B read addr 63 (memory holds 0xFF), A req raised during WAIT -> b_rvalid rdata 0xFF, then a_gnt next ISSUE; no overlap.
REQ-034 Reset asserted mid-WAIT of A read -> a_rvalid never pulses, busy 0 immediately, outputs 0.
REQ-035 Continuous A req, no B -> A granted every 2 cycles (writes); mem_read and mem_write never both high in any cycle.
